gpr_read_control: RTL and testbench
===================================

// Module: gpr_read_control
// PURPOSE
// - Read-side counterpart of the register-file write control: resolves the operand
//   file address and sources the operand byte for the ALU each instruction cycle.
// - Resolves direct/INDF (via FSR) addressing and FSR bank select, then muxes SFRs
//   against the synchronous GPR RAM.
// - Forwards a same-cycle write, then holds the registered operand until the next EX_Q2.
// PARAMETERS
// - DATA_WIDTH   8    operand/register width
// - ADDR_WIDTH   7    effective file address width (4 banks x 32)
// - BANK_BITS    2    FSR bank bits used, FSR[6:5]
// PORTS
// - clk           in   1               system clock, rising edge
// - rst_n         in   1               asynchronous active-low reset
// - executeState  in   EX_STATE_BITS   execute Q-state from the control unit
// - irFileAddr    in   5               IR[4:0] file field
// - fsrIn         in   8               current FSR value
// - statusIn      in   8               STATUS register
// - tmr0In        in   8               TMR0 value
// - pclIn         in   8               PCL value
// - portAIn       in   4               PORTA pins
// - portBIn       in   8               PORTB pins
// - portCIn       in   8               PORTC pins
// - ramAddrOut    out  7               GPR RAM read address
// - ramRdEnOut    out  1               GPR RAM read enable
// - ramDataIn     in   8               GPR RAM data, valid 1 clk after ramRdEnOut
// - wrEnIn        in   1               register-file write strobe (Q4 GPR write)
// - wrAddrIn      in   7               effective address of that write
// - wrDataIn      in   8               data of that write
// - effAddrOut    out  7               latched effective address, for the write side
// - readDataOut   out  8               registered operand
// - readValidOut  out  1               readDataOut holds this instruction's operand
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; effAddrOut=0; readDataOut=0; readValidOut=0;
//   ramRdEnOut=0; ramAddrOut=0.
// - Address resolution (combinational):
//   - f = irFileAddr; if f==0 (INDF), f = fsrIn[4:0] and bank = fsrIn[6:5],
//     else bank = fsrIn[6:5].
//   - eff = f[4] ? {bank, f} : {2'b00, f}. Addresses 0x00-0x0F alias to bank 0.
// - FSM states: IDLE -> ADDR -> CAPT -> HOLD.
//   - IDLE/HOLD -> ADDR when executeState==EX_Q2.
//     - On that clock: latch eff into effAddrOut; clear readValidOut; latch the SFR select.
//   - ADDR -> CAPT unconditionally.
//     - During ADDR: ramRdEnOut=1 and ramAddrOut=effAddrOut, but only when eff[4:0]>=0x08.
//   - CAPT -> HOLD unconditionally.
//     - On the CAPT clock: readDataOut is loaded by source priority (below) and readValidOut=1.
//   - HOLD: outputs stable until the next EX_Q2.
// - Source priority at CAPT:
//   1. Forward: wrEnIn && wrAddrIn==effAddrOut -> wrDataIn.
//   2. Indirect through FSR==0 (INDF of INDF) -> 0x00.
//   3. SFRs:
//      - 0x01 tmr0In; 0x02 pclIn; 0x03 statusIn.
//      - 0x04 {1'b1, fsrIn[6:0]} (FSR[7] reads as 1).
//      - 0x05 {4'h0, portAIn}; 0x06 portBIn; 0x07 portCIn.
//   4. Otherwise ramDataIn.
// - Latency: operand valid 2 clk after the EX_Q2 clock (fixed, no stall).
// - EX_Q2 arriving in ADDR or CAPT: abort, re-latch the new address, restart at ADDR;
//   readValidOut stays 0.
// - SFR values are sampled at CAPT, not at EX_Q2.
// - Reset mid-operation returns to IDLE immediately; no RAM read is issued after rst_n deasserts
//   until the next EX_Q2.
// STRUCTURE
// - Shared definitions go in define.v:
//   - SFR address constants (ADDR_INDF..ADDR_PORTC).
//   - GPR base 0x08 and banked base 0x10.
//   - The FSM state encoding.
// - One natural sub-module: gpr_addr_resolve (pure combinational eff/bank/isSfr decode),
//   reused by the write side for wrAddrIn.
// TESTING
// 1. Direct GPR: irFileAddr=0x0A, RAM[0x0A]=0x5C, EX_Q2
//    -> ramAddrOut=0x0A in ADDR; readDataOut=0x5C, readValidOut=1 two clk later.
// 2. Banked: fsrIn=0x60, irFileAddr=0x12 -> effAddrOut=0x72.
//    Same with irFileAddr=0x0C -> effAddrOut=0x0C.
// 3. INDF: irFileAddr=0, fsrIn=0x35, RAM[0x35]=0xA1 -> readDataOut=0xA1.
//    With fsrIn=0x00 -> readDataOut=0x00 and no RAM access.
// 4. SFR:
//    - irFileAddr=0x04, fsrIn=0x12 -> 0x92.
//    - irFileAddr=0x05, portAIn=0xB -> 0x0B.
//    - ramRdEnOut stays 0 for both.
// 5. Forward: at CAPT wrEnIn=1, wrAddrIn=effAddrOut=0x1F, wrDataIn=0x77, RAM=0x11 -> readDataOut=0x77.
// 6. Reset/abort:
//    - rst_n=0 during ADDR -> all outputs 0 asynchronously.
//    - EX_Q2 in CAPT -> readValidOut stays 0 and the new address is latched.

Source files
------------

// File: rtl/gpr_read_control_pkg.sv
// Shared definitions for the register-file read side: Q-state and FSM encodings,
// SFR addresses and GPR/banked base addresses.
package gpr_read_control_pkg;

  localparam int EX_STATE_BITS = 2;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1 = 2'd0,
    EX_Q2 = 2'd1,
    EX_Q3 = 2'd2,
    EX_Q4 = 2'd3
  } ex_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CAPT = 2'd2,
    ST_HOLD = 2'd3
  } rd_state_e;

  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;
  localparam logic [4:0] ADDR_PORTA  = 5'h05;
  localparam logic [4:0] ADDR_PORTB  = 5'h06;
  localparam logic [4:0] ADDR_PORTC  = 5'h07;

  localparam logic [4:0] GPR_BASE    = 5'h08;
  localparam logic [4:0] BANKED_BASE = 5'h10;

endpackage

// File: rtl/gpr_read_control_addr_resolve.sv
// Combinational file-address decode: INDF substitution, bank select and SFR flags.
// Also usable on the write side to resolve wrAddrIn.
module gpr_addr_resolve
  import gpr_read_control_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_BITS  = 2
) (
  input  logic [4:0]            file_addr,
  input  logic [ADDR_WIDTH-1:0] fsr,
  output logic [ADDR_WIDTH-1:0] eff,
  output logic                  is_sfr,
  output logic                  is_indf
);

  logic [4:0]           f_field;
  logic [BANK_BITS-1:0] bank;

  always_comb begin
    f_field = (file_addr == ADDR_INDF) ? fsr[4:0] : file_addr;
    bank    = fsr[5 +: BANK_BITS];
    // Only the upper half of each bank is banked; 0x00-0x0F alias to bank 0.
    eff     = (f_field >= BANKED_BASE) ? {bank, f_field} : {{BANK_BITS{1'b0}}, f_field};
    is_sfr  = (f_field < GPR_BASE);
    is_indf = (f_field == ADDR_INDF);
  end

endmodule

// File: rtl/gpr_read_control.sv
// Operand read sequencer: latches the effective address at EX_Q2, reads GPR RAM or
// an SFR, forwards a coincident write and holds the operand until the next EX_Q2.
//
// state | meaning
// IDLE  | after reset, no operand yet
// ADDR  | address latched, RAM read in flight for GPR addresses
// CAPT  | operand source selected and registered on this clock
// HOLD  | operand valid and stable until next EX_Q2
module gpr_read_control
  import gpr_read_control_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int BANK_BITS  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EX_STATE_BITS-1:0] executeState,
  input  logic [4:0]               irFileAddr,
  input  logic [DATA_WIDTH-1:0]    fsrIn,
  input  logic [DATA_WIDTH-1:0]    statusIn,
  input  logic [DATA_WIDTH-1:0]    tmr0In,
  input  logic [DATA_WIDTH-1:0]    pclIn,
  input  logic [3:0]               portAIn,
  input  logic [DATA_WIDTH-1:0]    portBIn,
  input  logic [DATA_WIDTH-1:0]    portCIn,
  output logic [ADDR_WIDTH-1:0]    ramAddrOut,
  output logic                     ramRdEnOut,
  input  logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic                     wrEnIn,
  input  logic [ADDR_WIDTH-1:0]    wrAddrIn,
  input  logic [DATA_WIDTH-1:0]    wrDataIn,
  output logic [ADDR_WIDTH-1:0]    effAddrOut,
  output logic [DATA_WIDTH-1:0]    readDataOut,
  output logic                     readValidOut
);

  rd_state_e             state;
  logic [ADDR_WIDTH-1:0] eff;
  logic                  is_sfr;
  logic                  is_indf;
  logic                  sfr_q;
  logic                  indf_q;
  logic [2:0]            sfr_idx_q;
  logic [DATA_WIDTH-1:0] capt_data;
  logic                  unused_fsr_msb;

  assign unused_fsr_msb = fsrIn[DATA_WIDTH-1];

  gpr_addr_resolve #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_BITS  (BANK_BITS)
  ) u_resolve (
    .file_addr (irFileAddr),
    .fsr       (fsrIn[ADDR_WIDTH-1:0]),
    .eff       (eff),
    .is_sfr    (is_sfr),
    .is_indf   (is_indf)
  );

  always_comb begin
    capt_data = ramDataIn;
    if (wrEnIn && (wrAddrIn == effAddrOut)) begin
      capt_data = wrDataIn;
    end else if (indf_q) begin
      capt_data = '0;
    end else if (sfr_q) begin
      // SFR inputs are sampled live here, not at the EX_Q2 clock.
      unique case (sfr_idx_q)
        ADDR_TMR0[2:0]:   capt_data = tmr0In;
        ADDR_PCL[2:0]:    capt_data = pclIn;
        ADDR_STATUS[2:0]: capt_data = statusIn;
        ADDR_FSR[2:0]:    capt_data = {1'b1, fsrIn[DATA_WIDTH-2:0]};
        ADDR_PORTA[2:0]:  capt_data = {{(DATA_WIDTH-4){1'b0}}, portAIn};
        ADDR_PORTB[2:0]:  capt_data = portBIn;
        ADDR_PORTC[2:0]:  capt_data = portCIn;
        default:          capt_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      effAddrOut   <= '0;
      readDataOut  <= '0;
      readValidOut <= 1'b0;
      ramRdEnOut   <= 1'b0;
      ramAddrOut   <= '0;
      sfr_q        <= 1'b0;
      indf_q       <= 1'b0;
      sfr_idx_q    <= '0;
    end else if (executeState == EX_Q2) begin
      // Same action from every state: a new EX_Q2 aborts any read in flight.
      state        <= ST_ADDR;
      effAddrOut   <= eff;
      readValidOut <= 1'b0;
      sfr_q        <= is_sfr;
      indf_q       <= is_indf;
      sfr_idx_q    <= eff[2:0];
      ramRdEnOut   <= ~is_sfr;
      ramAddrOut   <= is_sfr ? '0 : eff;
    end else begin
      unique case (state)
        ST_ADDR: begin
          state      <= ST_CAPT;
          ramRdEnOut <= 1'b0;
          ramAddrOut <= '0;
        end
        ST_CAPT: begin
          state        <= ST_HOLD;
          readDataOut  <= capt_data;
          readValidOut <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_read_control.sv
// Directed bench for gpr_read_control with a one-cycle-latency GPR RAM model.
module tb_gpr_read_control;
  import gpr_read_control_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic [EX_STATE_BITS-1:0] executeState;
  logic [4:0]               irFileAddr;
  logic [7:0]               fsrIn, statusIn, tmr0In, pclIn, portBIn, portCIn;
  logic [3:0]               portAIn;
  logic [6:0]               ramAddrOut;
  logic                     ramRdEnOut;
  logic [7:0]               ramDataIn;
  logic                     wrEnIn;
  logic [6:0]               wrAddrIn;
  logic [7:0]               wrDataIn;
  logic [6:0]               effAddrOut;
  logic [7:0]               readDataOut;
  logic                     readValidOut;

  logic [7:0] mem [128];
  int checks = 0;
  int failures = 0;

  gpr_read_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .executeState (executeState),
    .irFileAddr   (irFileAddr),
    .fsrIn        (fsrIn),
    .statusIn     (statusIn),
    .tmr0In       (tmr0In),
    .pclIn        (pclIn),
    .portAIn      (portAIn),
    .portBIn      (portBIn),
    .portCIn      (portCIn),
    .ramAddrOut   (ramAddrOut),
    .ramRdEnOut   (ramRdEnOut),
    .ramDataIn    (ramDataIn),
    .wrEnIn       (wrEnIn),
    .wrAddrIn     (wrAddrIn),
    .wrDataIn     (wrDataIn),
    .effAddrOut   (effAddrOut),
    .readDataOut  (readDataOut),
    .readValidOut (readValidOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramRdEnOut) ramDataIn <= mem[ramAddrOut];
  end

  // Present EX_Q2 for exactly one rising edge; returns 1 ns after it (state ADDR).
  task automatic start_op(input logic [4:0] f, input logic [7:0] fsr);
    @(negedge clk);
    irFileAddr   = f;
    fsrIn        = fsr;
    executeState = EX_Q2;
    @(posedge clk);
    #1;
    executeState = EX_Q1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (effAddrOut !== 7'h00 || readDataOut !== 8'h00 || readValidOut !== 1'b0 ||
        ramRdEnOut !== 1'b0 || ramAddrOut !== 7'h00) begin
      failures++;
      $display("FAIL reset_outputs: eff=%h data=%h valid=%b rden=%b raddr=%h, need all 0",
               effAddrOut, readDataOut, readValidOut, ramRdEnOut, ramAddrOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (ramRdEnOut !== 1'b0 || readValidOut !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: rden=%b valid=%b, need 0 0", ramRdEnOut, readValidOut);
    end
  endtask

  task automatic test_direct_gpr();
    mem[7'h0A] = 8'h5C;
    start_op(5'h0A, 8'h00);
    checks++;
    if (ramRdEnOut !== 1'b1 || ramAddrOut !== 7'h0A || effAddrOut !== 7'h0A) begin
      failures++;
      $display("FAIL direct_addr: rden=%b raddr=%h eff=%h, need 1 0a 0a",
               ramRdEnOut, ramAddrOut, effAddrOut);
    end
    step();
    checks++;
    if (readValidOut !== 1'b0 || ramRdEnOut !== 1'b0) begin
      failures++;
      $display("FAIL direct_capt: valid=%b rden=%b, need 0 0", readValidOut, ramRdEnOut);
    end
    step();
    checks++;
    if (readDataOut !== 8'h5C || readValidOut !== 1'b1) begin
      failures++;
      $display("FAIL direct_data: data=%h valid=%b, need 5c 1", readDataOut, readValidOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'h5C || readValidOut !== 1'b1) begin
      failures++;
      $display("FAIL direct_hold: data=%h valid=%b, need 5c 1", readDataOut, readValidOut);
    end
  endtask

  task automatic test_banked();
    mem[7'h72] = 8'h3D;
    start_op(5'h12, 8'h60);
    checks++;
    if (effAddrOut !== 7'h72 || ramAddrOut !== 7'h72 || readValidOut !== 1'b0) begin
      failures++;
      $display("FAIL banked_addr: eff=%h raddr=%h valid=%b, need 72 72 0",
               effAddrOut, ramAddrOut, readValidOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'h3D) begin
      failures++;
      $display("FAIL banked_data: data=%h, need 3d", readDataOut);
    end
    start_op(5'h0C, 8'h60);
    checks++;
    if (effAddrOut !== 7'h0C || ramAddrOut !== 7'h0C) begin
      failures++;
      $display("FAIL alias_addr: eff=%h raddr=%h, need 0c 0c", effAddrOut, ramAddrOut);
    end
    step();
    step();
  endtask

  task automatic test_indf();
    mem[7'h35] = 8'hA1;
    start_op(5'h00, 8'h35);
    checks++;
    if (effAddrOut !== 7'h35 || ramRdEnOut !== 1'b1) begin
      failures++;
      $display("FAIL indf_addr: eff=%h rden=%b, need 35 1", effAddrOut, ramRdEnOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'hA1) begin
      failures++;
      $display("FAIL indf_data: data=%h, need a1", readDataOut);
    end
    start_op(5'h00, 8'h00);
    checks++;
    if (ramRdEnOut !== 1'b0) begin
      failures++;
      $display("FAIL indf0_rden: rden=%b, need 0", ramRdEnOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'h00 || readValidOut !== 1'b1) begin
      failures++;
      $display("FAIL indf0_data: data=%h valid=%b, need 00 1", readDataOut, readValidOut);
    end
  endtask

  task automatic test_sfr();
    start_op(5'h04, 8'h12);
    checks++;
    if (ramRdEnOut !== 1'b0) begin
      failures++;
      $display("FAIL fsr_rden: rden=%b, need 0", ramRdEnOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'h92) begin
      failures++;
      $display("FAIL fsr_data: data=%h, need 92", readDataOut);
    end
    portAIn = 4'hB;
    start_op(5'h05, 8'h00);
    checks++;
    if (ramRdEnOut !== 1'b0) begin
      failures++;
      $display("FAIL porta_rden: rden=%b, need 0", ramRdEnOut);
    end
    step();
    step();
    checks++;
    if (readDataOut !== 8'h0B) begin
      failures++;
      $display("FAIL porta_data: data=%h, need 0b", readDataOut);
    end
    // TMR0 changes after EX_Q2; the value present at CAPT must be taken.
    tmr0In = 8'h11;
    start_op(5'h01, 8'h00);
    tmr0In = 8'h3C;
    step();
    step();
    checks++;
    if (readDataOut !== 8'h3C) begin
      failures++;
      $display("FAIL tmr0_sample: data=%h, need 3c", readDataOut);
    end
    statusIn = 8'h18;
    start_op(5'h03, 8'h00);
    step();
    step();
    checks++;
    if (readDataOut !== 8'h18) begin
      failures++;
      $display("FAIL status_data: data=%h, need 18", readDataOut);
    end
  endtask

  task automatic test_forward();
    mem[7'h1F] = 8'h11;
    start_op(5'h1F, 8'h00);
    step();
    wrEnIn   = 1'b1;
    wrAddrIn = 7'h1F;
    wrDataIn = 8'h77;
    step();
    wrEnIn = 1'b0;
    checks++;
    if (readDataOut !== 8'h77) begin
      failures++;
      $display("FAIL forward_hit: data=%h, need 77", readDataOut);
    end
    start_op(5'h1F, 8'h00);
    step();
    wrEnIn   = 1'b1;
    wrAddrIn = 7'h1E;
    step();
    wrEnIn = 1'b0;
    checks++;
    if (readDataOut !== 8'h11) begin
      failures++;
      $display("FAIL forward_miss: data=%h, need 11", readDataOut);
    end
  endtask

  task automatic test_abort();
    mem[7'h0B] = 8'hE4;
    start_op(5'h0A, 8'h00);
    step();
    @(negedge clk);
    irFileAddr   = 5'h0B;
    executeState = EX_Q2;
    @(posedge clk);
    #1;
    executeState = EX_Q1;
    checks++;
    if (readValidOut !== 1'b0 || effAddrOut !== 7'h0B || ramAddrOut !== 7'h0B ||
        ramRdEnOut !== 1'b1) begin
      failures++;
      $display("FAIL abort_relatch: valid=%b eff=%h raddr=%h rden=%b, need 0 0b 0b 1",
               readValidOut, effAddrOut, ramAddrOut, ramRdEnOut);
    end
    step();
    checks++;
    if (readValidOut !== 1'b0) begin
      failures++;
      $display("FAIL abort_capt_valid: valid=%b, need 0", readValidOut);
    end
    step();
    checks++;
    if (readDataOut !== 8'hE4 || readValidOut !== 1'b1) begin
      failures++;
      $display("FAIL abort_data: data=%h valid=%b, need e4 1", readDataOut, readValidOut);
    end
  endtask

  task automatic test_reset_mid();
    start_op(5'h0A, 8'h00);
    rst_n = 1'b0;
    #1;
    checks++;
    if (effAddrOut !== 7'h00 || readDataOut !== 8'h00 || readValidOut !== 1'b0 ||
        ramRdEnOut !== 1'b0 || ramAddrOut !== 7'h00) begin
      failures++;
      $display("FAIL reset_mid: eff=%h data=%h valid=%b rden=%b raddr=%h, need all 0",
               effAddrOut, readDataOut, readValidOut, ramRdEnOut, ramAddrOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ramRdEnOut !== 1'b0 || readValidOut !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_read: cycle=%0d rden=%b valid=%b, need 0 0",
                 i, ramRdEnOut, readValidOut);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst_n        = 1'b0;
    executeState = EX_Q1;
    irFileAddr   = 5'h00;
    fsrIn        = 8'h00;
    statusIn     = 8'h00;
    tmr0In       = 8'h00;
    pclIn        = 8'h00;
    portAIn      = 4'h0;
    portBIn      = 8'h00;
    portCIn      = 8'h00;
    ramDataIn    = 8'h00;
    wrEnIn       = 1'b0;
    wrAddrIn     = 7'h00;
    wrDataIn     = 8'h00;

    test_reset();
    test_direct_gpr();
    test_banked();
    test_indf();
    test_sfr();
    test_forward();
    test_abort();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
